// File: rtl/ay_bus_regfile.sv
// ---------------------------------------------------------------------------
// ay_bus_regfile
//   Bus-interface controller and register file for the AY-3-8913 sound core.
//   Decodes the BDIR/BC2/BC1 bus protocol, latches the register address
//   together with chip-select, stores R0..R15, fans the stored values out to
//   the tone/noise/mixer/envelope datapaths and produces the envelope-restart
//   strobe plus registered readback.
//
//   Build option: define AY_READ_MASK_EN for AY-3-8910 style readback, where
//   unused register bits read back as zero. Without it (YM2149 style) all
//   8 stored bits are returned. The output buses are identical in both builds.
//
// Parameters
//   CHIP_ADDR_HI       value data_in_i[7:4] must match on address latch
//   NOISE_PERIOD_BITS  width of noise_period_o (must be <= 8)
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   bdir_i, bc2_i, bc1_i          bus mode, already synchronised to clk
//   a8_i, a9_n_i                  chip-select address lines
//   data_in_i[7:0]                bus data into the chip
//   data_out_o[7:0], data_oe_o    registered readback data / drive enable
//   tone_period_{a,b,c}_o[11:0]   {R1[3:0],R0}, {R3[3:0],R2}, {R5[3:0],R4}
//   noise_period_o                R6[NOISE_PERIOD_BITS-1:0]
//   tone_disable_o[2:0]           R7[2:0]
//   noise_disable_o[2:0]          R7[5:3]
//   amplitude_{a,b,c}_o[4:0]      R8[4:0], R9[4:0], R10[4:0]
//   env_period_o[15:0]            {R12,R11}
//   env_shape_o[3:0]              R13[3:0]
//   env_restart_o                 one-cycle pulse after a write burst to R13
// ---------------------------------------------------------------------------
module ay_bus_regfile #(
  parameter logic [3:0] CHIP_ADDR_HI      = 4'h0,
  parameter int         NOISE_PERIOD_BITS = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bdir_i,
  input  logic                         bc2_i,
  input  logic                         bc1_i,
  input  logic                         a8_i,
  input  logic                         a9_n_i,
  input  logic [7:0]                   data_in_i,
  output logic [7:0]                   data_out_o,
  output logic                         data_oe_o,
  output logic [11:0]                  tone_period_a_o,
  output logic [11:0]                  tone_period_b_o,
  output logic [11:0]                  tone_period_c_o,
  output logic [NOISE_PERIOD_BITS-1:0] noise_period_o,
  output logic [2:0]                   tone_disable_o,
  output logic [2:0]                   noise_disable_o,
  output logic [4:0]                   amplitude_a_o,
  output logic [4:0]                   amplitude_b_o,
  output logic [4:0]                   amplitude_c_o,
  output logic [15:0]                  env_period_o,
  output logic [3:0]                   env_shape_o,
  output logic                         env_restart_o
);

  logic [7:0] regs_q [16];
  logic [3:0] addr_q;
  logic       selected_q;
  logic       wr_prev_q;      // previous cycle was a WRITE (burst tracker)
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       env_restart_q, env_restart_d;

  logic [2:0] mode;
  logic       is_latch, is_read, is_write;
  logic       sel_d;
  logic [7:0] rd_data;

`ifdef AY_READ_MASK_EN
  // Bits that exist in the original AY-3-8910 register map.
  function automatic logic [7:0] rd_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: rd_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: rd_mask = 8'h1F;
      default:                 rd_mask = 8'hFF;
    endcase
  endfunction
`endif

  // Bus-mode decode
  assign mode     = {bdir_i, bc2_i, bc1_i};
  assign is_latch = (mode == 3'b001) || (mode == 3'b100) || (mode == 3'b111);
  assign is_read  = (mode == 3'b011);
  assign is_write = (mode == 3'b110);
  assign sel_d    = (data_in_i[7:4] == CHIP_ADDR_HI) & a8_i & ~a9_n_i;

  always_comb begin
    rd_data = regs_q[addr_q];
`ifdef AY_READ_MASK_EN
    rd_data = rd_data & rd_mask(addr_q);
`endif
  end

  always_comb begin
    data_oe_d     = is_read & selected_q;
    data_out_d    = data_oe_d ? rd_data : 8'h00;
    // Only the first cycle of a contiguous write burst to R13 restarts.
    env_restart_d = is_write & selected_q & (addr_q == 4'd13) & ~wr_prev_q;
  end

  // Register stage: bus state, storage and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      addr_q        <= 4'h0;
      selected_q    <= 1'b0;
      wr_prev_q     <= 1'b0;
      data_out_q    <= 8'h00;
      data_oe_q     <= 1'b0;
      env_restart_q <= 1'b0;
    end else begin
      if (is_latch) begin
        addr_q     <= data_in_i[3:0];
        selected_q <= sel_d;
      end
      if (is_write && selected_q) regs_q[addr_q] <= data_in_i;
      wr_prev_q     <= is_write;
      data_out_q    <= data_out_d;
      data_oe_q     <= data_oe_d;
      env_restart_q <= env_restart_d;
    end
  end

  assign data_out_o      = data_out_q;
  assign data_oe_o       = data_oe_q;
  assign env_restart_o   = env_restart_q;
  assign tone_period_a_o = {regs_q[1][3:0], regs_q[0]};
  assign tone_period_b_o = {regs_q[3][3:0], regs_q[2]};
  assign tone_period_c_o = {regs_q[5][3:0], regs_q[4]};
  assign noise_period_o  = regs_q[6][NOISE_PERIOD_BITS-1:0];
  assign tone_disable_o  = regs_q[7][2:0];
  assign noise_disable_o = regs_q[7][5:3];
  assign amplitude_a_o   = regs_q[8][4:0];
  assign amplitude_b_o   = regs_q[9][4:0];
  assign amplitude_c_o   = regs_q[10][4:0];
  assign env_period_o    = {regs_q[12], regs_q[11]};
  assign env_shape_o     = regs_q[13][3:0];

endmodule

// File: tb/tb_ay_bus_regfile.sv
// Testbench for ay_bus_regfile: directed steps followed by randomized bus
// traffic, checked against a register-map model held in plain arrays.
module tb_ay_bus_regfile;
  localparam int NPB = 5;
  localparam logic [2:0] M_I = 3'b000, M_L1 = 3'b001, M_L4 = 3'b100,
                         M_L7 = 3'b111, M_R = 3'b011, M_W = 3'b110;

  logic clk = 1'b0;
  logic reset, bdir, bc2, bc1, a8, a9n;
  logic [7:0] din, dout;
  logic doe, env_restart;
  logic [11:0] tpa, tpb, tpc;
  logic [NPB-1:0] np;
  logic [2:0] tdis, ndis;
  logic [4:0] ampa, ampb, ampc;
  logic [15:0] envp;
  logic [3:0] envs;

  always #5 clk = ~clk;

  ay_bus_regfile #(.CHIP_ADDR_HI(4'h0), .NOISE_PERIOD_BITS(NPB)) dut (
    .clk(clk), .reset(reset), .bdir_i(bdir), .bc2_i(bc2), .bc1_i(bc1),
    .a8_i(a8), .a9_n_i(a9n), .data_in_i(din), .data_out_o(dout),
    .data_oe_o(doe), .tone_period_a_o(tpa), .tone_period_b_o(tpb),
    .tone_period_c_o(tpc), .noise_period_o(np), .tone_disable_o(tdis),
    .noise_disable_o(ndis), .amplitude_a_o(ampa), .amplitude_b_o(ampb),
    .amplitude_c_o(ampc), .env_period_o(envp), .env_shape_o(envs),
    .env_restart_o(env_restart)
  );

  // Reference model state
  logic [7:0] mr [16];
  logic [7:0] rmask [16];
  logic [3:0] m_addr;
  logic       m_sel, m_prev;
  logic [7:0] e_dout;
  logic       e_oe, e_rst;
  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tone_a", 32'(tpa), 32'({mr[1][3:0], mr[0]}));
    chk("tone_b", 32'(tpb), 32'({mr[3][3:0], mr[2]}));
    chk("tone_c", 32'(tpc), 32'({mr[5][3:0], mr[4]}));
    chk("noise_period", 32'(np), 32'(mr[6] % 8'd32));
    chk("tone_disable", 32'(tdis), 32'(mr[7] % 8'd8));
    chk("noise_disable", 32'(ndis), 32'((mr[7] / 8'd8) % 8'd8));
    chk("amp_a", 32'(ampa), 32'(mr[8] % 8'd32));
    chk("amp_b", 32'(ampb), 32'(mr[9] % 8'd32));
    chk("amp_c", 32'(ampc), 32'(mr[10] % 8'd32));
    chk("env_period", 32'(envp), 32'(mr[12]) * 256 + 32'(mr[11]));
    chk("env_shape", 32'(envs), 32'(mr[13] % 8'd16));
    chk("env_restart", 32'(env_restart), 32'(e_rst));
    chk("data_oe", 32'(doe), 32'(e_oe));
    chk("data_out", 32'(dout), 32'(e_dout));
  endtask

  // One clock: drive, advance the model by the bus rules, then compare.
  task automatic step(input logic r, input logic [2:0] m, input logic [7:0] d,
                      input logic ia8, input logic ia9n);
    reset = r; {bdir, bc2, bc1} = m; din = d; a8 = ia8; a9n = ia9n;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) mr[i] = 8'h00;
      m_addr = 4'h0; m_sel = 1'b0; m_prev = 1'b0;
      e_dout = 8'h00; e_oe = 1'b0; e_rst = 1'b0;
    end else begin
      e_oe   = (m == M_R) && m_sel;
      e_dout = e_oe ? (mr[m_addr] & rmask[m_addr]) : 8'h00;
      e_rst  = (m == M_W) && m_sel && (m_addr == 4'd13) && !m_prev;
      if (m == M_W && m_sel) mr[m_addr] = d;
      if (m == M_L1 || m == M_L4 || m == M_L7) begin
        m_addr = d[3:0];
        m_sel  = (d[7:4] == 4'h0) && ia8 && !ia9n;
      end
      m_prev = (m == M_W);
    end
    #1;
    check_all();
    if (env_restart === 1'b1) pulses++;
  endtask

  initial begin
    logic [2:0] rm;
    logic [7:0] rd;
    for (int i = 0; i < 16; i++) rmask[i] = 8'hFF;
`ifdef AY_READ_MASK_EN
    rmask[1] = 8'h0F; rmask[3] = 8'h0F; rmask[5] = 8'h0F; rmask[13] = 8'h0F;
    rmask[6] = 8'h1F; rmask[8] = 8'h1F; rmask[9] = 8'h1F; rmask[10] = 8'h1F;
`endif
    for (int i = 0; i < 16; i++) mr[i] = 8'h00;
    m_addr = 4'h0; m_sel = 1'b0; m_prev = 1'b0;
    e_dout = 8'h00; e_oe = 1'b0; e_rst = 1'b0;

    // Reset state
    step(1, M_I, 8'h00, 0, 1);
    step(1, M_I, 8'h00, 0, 1);
    step(0, M_I, 8'h00, 0, 1);

    // R0 <= FF
    step(0, M_L7, 8'h00, 1, 0);
    step(0, M_W, 8'hFF, 1, 0);
    step(0, M_I, 8'h00, 1, 0);
    chk("tp_a_0FF", 32'(tpa), 32'h0FF);

    // R1 <= AB, read back
    step(0, M_L1, 8'h01, 1, 0);
    step(0, M_W, 8'hAB, 1, 0);
    step(0, M_I, 8'h00, 1, 0);
    chk("tp_a_BFF", 32'(tpa), 32'hBFF);
    step(0, M_R, 8'h00, 1, 0);
    chk("r1_oe", 32'(doe), 32'h1);
`ifdef AY_READ_MASK_EN
    chk("r1_read", 32'(dout), 32'h0B);
`else
    chk("r1_read", 32'(dout), 32'hAB);
`endif
    step(0, M_I, 8'h00, 1, 0);
    chk("r1_oe_off", 32'(doe), 32'h0);

    // Envelope restart: held write pulses once, gap re-arms
    pulses = 0;
    step(0, M_L4, 8'h0D, 1, 0);
    for (int i = 0; i < 3; i++) step(0, M_W, 8'h0E, 1, 0);
    step(0, M_I, 8'h00, 1, 0);
    step(0, M_W, 8'h0E, 1, 0);
    step(0, M_I, 8'h00, 1, 0);
    step(0, M_I, 8'h00, 1, 0);
    chk("env_pulses", 32'(pulses), 32'd2);
    chk("env_shape_E", 32'(envs), 32'hE);

    // Deselected by upper nibble, then by a9_n
    step(0, M_L7, 8'h17, 1, 0);
    step(0, M_W, 8'h3F, 1, 0);
    step(0, M_R, 8'h00, 1, 0);
    chk("desel_hi_tdis", 32'(tdis), 32'h0);
    chk("desel_hi_oe", 32'(doe), 32'h0);
    step(0, M_L7, 8'h07, 1, 1);
    step(0, M_W, 8'h3F, 1, 1);
    step(0, M_R, 8'h00, 1, 1);
    chk("desel_a9_tdis", 32'(tdis), 32'h0);
    chk("desel_a9_oe", 32'(doe), 32'h0);

    // Envelope period and noise period
    step(0, M_L7, 8'h0B, 1, 0); step(0, M_W, 8'h34, 1, 0);
    step(0, M_L7, 8'h0C, 1, 0); step(0, M_W, 8'h12, 1, 0);
    step(0, M_I, 8'h00, 1, 0);
    chk("env_period_1234", 32'(envp), 32'h1234);
    step(0, M_L7, 8'h06, 1, 0); step(0, M_W, 8'hFF, 1, 0);
    step(0, M_I, 8'h00, 1, 0);
    chk("noise_1F", 32'(np), 32'h1F);

    // Reset during a held write to R8
    step(0, M_L7, 8'h08, 1, 0);
    step(1, M_W, 8'h15, 1, 0);
    step(0, M_W, 8'h15, 1, 0);
    step(0, M_W, 8'h15, 1, 0);
    chk("rst_amp_a", 32'(ampa), 32'h0);
    step(0, M_R, 8'h00, 1, 0);
    chk("rst_oe", 32'(doe), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);

    // Every register: write random value, read it back
    for (int a = 0; a < 16; a++) begin
      step(0, M_L7, 8'(a), 1, 0);
      step(0, M_W, 8'($urandom_range(0, 255)), 1, 0);
      step(0, M_R, 8'h00, 1, 0);
      step(0, M_I, 8'h00, 1, 0);
    end

    // Randomized bus traffic
    for (int n = 0; n < 400; n++) begin
      rm = 3'($urandom_range(0, 7));
      rd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) rd[7:4] = 4'h0;
      step(($urandom_range(0, 49) == 0), rm, rd,
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
